uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (trmt / tx_data / tx_done handshake, 8N1, tx_done high when idle) between NUM_REQ telemetry requesters on the line-follower chip.
- Round-robin arbitration with packet lock: a requester keeps the transmitter until it sends a byte flagged last.
- Sequences each byte through the transmitter: one-cycle trmt launch, wait for tx_done to fall, then wait for it to rise.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one UART transmitter among NUM_REQ requesters.
// Optional build macro UART_ARB_PRIO0_EN gives requester 0 fixed priority whenever no packet is locked.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic [IDXW-1:0]        owner,
    output logic                   busy,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done
);

    // Handshakes:
    //   requester side: req[i] is a level held with req_data/req_last stable until ack[i] pulses for
    //   one cycle; the byte is captured at the edge that raises ack, and at most one ack bit is ever high.
    //   transmitter side: trmt pulses one cycle; tx_done is expected to fall and then rise again,
    //   and a missing fall is tolerated after four cycles.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                lock;
    logic [IDXW-1:0]     rr_ptr;
    logic [1:0]          wb_cnt;

    logic                rr_valid;
    logic [IDXW-1:0]     rr_idx;
    logic [IDXW-1:0]     scan_idx;
    logic                pick_valid;
    logic [IDXW-1:0]     pick_idx;
    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDXW-1:0]     next_ptr;
    logic                advance_ptr;

    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDXW'(s);
    endfunction

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = wrap_add(rr_ptr, k);
            if (!rr_valid && req[scan_idx]) begin
                rr_valid = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        if (lock) begin
            pick_valid = req[owner];
            pick_idx   = owner;
        end
`ifdef UART_ARB_PRIO0_EN
        else if (req[0]) begin
            pick_valid = 1'b1;
            pick_idx   = '0;
        end
`endif
        else begin
            pick_valid = rr_valid;
            pick_idx   = rr_idx;
        end
    end

    assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign next_ptr = (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_PRIO0_EN
    assign advance_ptr = (owner != '0);
`else
    assign advance_ptr = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_valid) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!tx_done || wb_cnt == 2'd3) state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            ack     <= '0;
            grant   <= '0;
            owner   <= '0;
            trmt    <= 1'b0;
            tx_data <= '0;
            wb_cnt  <= '0;
        end else begin
            ack  <= '0;
            trmt <= (state_nxt == LAUNCH);
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        tx_data <= req_data[{pick_idx, 3'b000} +: 8];
                        owner   <= pick_idx;
                        grant   <= pick_oh;
                        ack     <= pick_oh;
                        lock    <= ~req_last[pick_idx];
                    end else if (lock) begin
                        // Owner went quiet mid-packet: drop the lock so others are not starved.
                        lock  <= 1'b0;
                        grant <= '0;
                    end
                end
                LAUNCH:    wb_cnt <= '0;
                WAIT_BUSY: wb_cnt <= wb_cnt + 2'd1;
                WAIT_DONE: begin
                    if (tx_done && !lock) begin
                        grant <= '0;
                        if (advance_ptr) rr_ptr <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte queues, transmitter model, in-order scoreboard.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDXW    = 2;
    localparam int BYTE_T  = 12;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [8*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ-1:0]    ack;
    logic [NUM_REQ-1:0]    grant;
    logic [IDXW-1:0]       owner;
    logic                  busy;
    logic                  trmt;
    logic [7:0]            tx_data;
    logic                  tx_done = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int trmt_total = 0;
    int prev_cyc   = 0;
    bit prev_valid = 1'b0;
    bit gap_en     = 1'b0;
    bit tx_stuck   = 1'b0;
    int tx_cnt     = 0;

    logic [IDXW+7:0] exp_q[$];
    logic [8:0]      src_mem [NUM_REQ][8];
    int              src_rd  [NUM_REQ];
    int              src_wr  [NUM_REQ];

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Transmitter model: tx_done low for BYTE_T cycles starting the cycle after trmt.
    always @(posedge clk) begin
        if (trmt && !tx_stuck) begin
            tx_done <= 1'b0;
            tx_cnt  <= BYTE_T - 1;
        end else if (!tx_done) begin
            if (tx_cnt == 0) tx_done <= 1'b1;
            else             tx_cnt  <= tx_cnt - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        src_mem[i][src_wr[i] % 8] = {last, d};
        src_wr[i]++;
    endtask

    task automatic exp_push(input int i, input logic [7:0] d);
        exp_q.push_back({IDXW'(i), d});
    endtask

    task automatic apply_reqs();
        logic [8:0] ent;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_rd[i] != src_wr[i]) begin
                ent = src_mem[i][src_rd[i] % 8];
                req[i] = 1'b1;
                req_data[8*i +: 8] = ent[7:0];
                req_last[i] = ent[8];
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [IDXW+7:0] e;
        if (ack != '0) begin
            check_eq("ack_onehot", 32'($onehot(ack)), 32'd1);
            check_eq("ack_eq_grant", 32'(ack), 32'(grant));
            check_eq("ack_with_trmt", 32'(trmt), 32'd1);
        end
        if (trmt) begin
            trmt_total++;
            check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("trmt_owner", 32'(owner), 32'(e[IDXW+7:8]));
                check_eq("trmt_data", 32'(tx_data), 32'(e[7:0]));
            end
            if (gap_en && prev_valid)
                check_eq("trmt_gap", 32'(cyc - prev_cyc), 32'(BYTE_T + 3));
            prev_cyc   = cyc;
            prev_valid = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        for (int i = 0; i < NUM_REQ; i++)
            if (ack[i]) src_rd[i]++;
        apply_reqs();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_served(input int count, input int limit);
        int n;
        int target;
        n = 0;
        target = trmt_total + count;
        while (trmt_total < target && n < limit) begin
            tick();
            n++;
        end
        check_eq("bytes_served", 32'(trmt_total), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end

        // Reset values
        tick();
        tick();
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_trmt", 32'(trmt), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single byte from requester 2
        push_byte(2, 8'hA5, 1'b1);
        exp_push(2, 8'hA5);
        apply_reqs();
        tick();
        check_eq("single_trmt", 32'(trmt), 32'd1);
        check_eq("single_ack", 32'(ack), 32'b0100);
        check_eq("single_grant", 32'(grant), 32'b0100);
        check_eq("single_tx_data", 32'(tx_data), 32'hA5);
        check_eq("single_owner", 32'(owner), 32'd2);
        tick();
        check_eq("single_trmt_one_cycle", 32'(trmt), 32'd0);
        repeat (4) tick();
        check_eq("single_grant_held", 32'(grant), 32'b0100);
        check_eq("single_busy_mid", 32'(busy), 32'd1);
        wait_idle(60);
        check_eq("single_grant_done", 32'(grant), 32'd0);
        check_eq("single_data_stable", 32'(tx_data), 32'hA5);

        // rr_ptr should now be 3: requester 3 beats requester 1
        push_byte(1, 8'h61, 1'b1);
        push_byte(3, 8'h63, 1'b1);
        exp_push(3, 8'h63);
        exp_push(1, 8'h61);
        apply_reqs();
        wait_served(2, 80);
        wait_idle(60);

        // Round robin, all requesters, from reset
        do_reset();
        push_byte(0, 8'h30, 1'b1);
        push_byte(1, 8'h31, 1'b1);
        push_byte(2, 8'h32, 1'b1);
        push_byte(3, 8'h33, 1'b1);
        push_byte(0, 8'h40, 1'b1);
`ifdef UART_ARB_PRIO0_EN
        exp_push(0, 8'h30); exp_push(0, 8'h40); exp_push(1, 8'h31);
        exp_push(2, 8'h32); exp_push(3, 8'h33);
`else
        exp_push(0, 8'h30); exp_push(1, 8'h31); exp_push(2, 8'h32);
        exp_push(3, 8'h33); exp_push(0, 8'h40);
`endif
        apply_reqs();
        gap_en = 1'b1;
        prev_valid = 1'b0;
        wait_served(5, 200);
        wait_idle(60);

        // Packet lock: requester 1 keeps the link for its three bytes
        prev_valid = 1'b0;
        push_byte(1, 8'h10, 1'b0);
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b1);
        push_byte(0, 8'h55, 1'b1);
`ifdef UART_ARB_PRIO0_EN
        exp_push(0, 8'h55);
        exp_push(1, 8'h10); exp_push(1, 8'h11); exp_push(1, 8'h12);
`else
        exp_push(1, 8'h10); exp_push(1, 8'h11); exp_push(1, 8'h12);
        exp_push(0, 8'h55);
`endif
        apply_reqs();
        wait_served(4, 200);
        wait_idle(60);
        gap_en = 1'b0;

        // Lock release: owner 3 drops mid-packet, requester 1 waiting
        push_byte(3, 8'h77, 1'b0);
        exp_push(3, 8'h77);
        apply_reqs();
        tick();
        check_eq("lockrel_ack3", 32'(ack), 32'b1000);
        push_byte(1, 8'h88, 1'b1);
        exp_push(1, 8'h88);
        apply_reqs();
        wait_idle(60);
        check_eq("lockrel_grant_held", 32'(grant), 32'b1000);
        tick();
        check_eq("lockrel_grant_clear", 32'(grant), 32'd0);
        check_eq("lockrel_no_ack_yet", 32'(ack), 32'd0);
        tick();
        check_eq("lockrel_ack1", 32'(ack), 32'b0010);
        wait_idle(60);

        // Reset in the middle of a byte
        push_byte(2, 8'h3C, 1'b1);
        exp_push(2, 8'h3C);
        apply_reqs();
        tick();
        repeat (5) tick();
        check_eq("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_grant", 32'(grant), 32'd0);
        check_eq("midrst_trmt", 32'(trmt), 32'd0);
        check_eq("midrst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 40 && !tx_done; n++) tick();
        push_byte(1, 8'h5A, 1'b1);
        exp_push(1, 8'h5A);
        apply_reqs();
        tick();
        check_eq("midrst_new_trmt", 32'(trmt), 32'd1);
        check_eq("midrst_new_owner", 32'(owner), 32'd1);
        wait_idle(60);

        // rr_ptr is 2 here: requesters 0 and 2 both ask
        push_byte(0, 8'h01, 1'b1);
        push_byte(2, 8'h02, 1'b1);
`ifdef UART_ARB_PRIO0_EN
        exp_push(0, 8'h01); exp_push(2, 8'h02);
`else
        exp_push(2, 8'h02); exp_push(0, 8'h01);
`endif
        apply_reqs();
        wait_served(2, 80);
        wait_idle(60);

        // Transmitter never drops tx_done: WAIT_BUSY gives up after four cycles
        tx_stuck = 1'b1;
        push_byte(3, 8'h99, 1'b1);
        exp_push(3, 8'h99);
        apply_reqs();
        tick();
        check_eq("stuck_trmt", 32'(trmt), 32'd1);
        repeat (5) tick();
        check_eq("stuck_busy_l5", 32'(busy), 32'd1);
        tick();
        check_eq("stuck_idle_l6", 32'(busy), 32'd0);
        tx_stuck = 1'b0;
        tick();

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
